// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the arbitrated UART transmitter
package uart_pkg;

  // Divider field width in the config struct; the top zero-extends its DIV_W-bit divider into it.
  localparam int unsigned CFG_DIV_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } uart_state_e;

  typedef struct packed {
    logic [CFG_DIV_W-1:0] div;
    logic                 parity_en;
    logic                 parity_type;
    logic                 stop2;
    logic [3:0]           data_bits;
  } uart_cfg_t;

  // Requested data-bit count limited to the legal 5..8 range.
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] n);
    logic [3:0] r;
    if (n < 4'd5) begin
      r = 4'd5;
    end else if (n > 4'd8) begin
      r = 4'd8;
    end else begin
      r = n;
    end
    return r;
  endfunction

  // XOR of the low n data bits, inverted for odd parity.
  function automatic logic calc_parity(input logic [7:0] d, input logic [3:0] n,
                                       input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(n)) begin
        p = p ^ d[i];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART serializer: baud counter, bit counter and frame FSM
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic       clk_i,
  input  logic       arst_ni,
  input  logic       start_i,
  input  uart_cfg_t  cfg_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o
);

  uart_state_e          state_q;
  uart_state_e          state_d;
  uart_cfg_t            cfg_q;
  logic [7:0]           shreg_q;
  logic                 par_q;
  logic [DIV_W-1:0]     baud_cnt_q;
  logic [2:0]           bit_cnt_q;
  logic [CFG_DIV_W-1:0] div_eff;
  logic [3:0]           n_bits;
  logic                 bit_end;
  logic                 last_data;

  // A zero divider behaves as one cycle per bit.
  assign div_eff   = (cfg_q.div == '0) ? CFG_DIV_W'(1) : cfg_q.div;
  assign bit_end   = (CFG_DIV_W'(baud_cnt_q) == (div_eff - CFG_DIV_W'(1)));
  assign n_bits    = clamp_data_bits(cfg_q.data_bits);
  assign last_data = ({1'b0, bit_cnt_q} == (n_bits - 4'd1));

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and line output.
  always_comb begin
    state_d = state_q;
    tx_o    = 1'b1;
    busy_o  = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx_o = 1'b0;
        if (bit_end) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_o = shreg_q[0];
        if (bit_end && last_data) begin
          state_d = cfg_q.parity_en ? ST_PARITY : ST_STOP1;
        end
      end
      ST_PARITY: begin
        tx_o = par_q;
        if (bit_end) begin
          state_d = ST_STOP1;
        end
      end
      ST_STOP1: begin
        if (bit_end) begin
          state_d = cfg_q.stop2 ? ST_STOP2 : ST_IDLE;
        end
      end
      ST_STOP2: begin
        if (bit_end) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame datapath: capture on start, then pace bits and shift data out LSB first.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cfg_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else if (state_q == ST_IDLE) begin
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      if (start_i) begin
        cfg_q   <= cfg_i;
        shreg_q <= data_i;
        par_q   <= calc_parity(data_i, clamp_data_bits(cfg_i.data_bits), cfg_i.parity_type);
      end
    end else if (bit_end) begin
      baud_cnt_q <= '0;
      if (state_q == ST_DATA) begin
        shreg_q   <= {1'b0, shreg_q[7:1]};
        bit_cnt_q <= last_data ? 3'd0 : (bit_cnt_q + 3'd1);
      end
    end else begin
      baud_cnt_q <= baud_cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding bytes from several requesters to one UART
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DIV_W   = 16
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic [DIV_W-1:0]           cfg_clk_div_i,
  input  logic                       cfg_parity_en_i,
  input  logic                       cfg_parity_type_i,
  input  logic                       cfg_stop2_i,
  input  logic [3:0]                 cfg_data_bits_i,
  input  logic [NUM_REQ-1:0][7:0]    req_data_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       tx_o,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    grant_q;
  logic [ID_W-1:0]    sel;
  logic               found;
  logic               handshake;
  logic               core_busy;
  logic [NUM_REQ-1:0] ready_vec;
  uart_cfg_t          cfg_d;

  // Round-robin pick: first valid requester after the last one granted.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      logic [ID_W-1:0] cand;
      cand = ID_W'((int'(ptr_q) + i) % int'(NUM_REQ));
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign handshake = !core_busy && found;
  assign ready_vec = handshake ? (NUM_REQ'(1) << sel) : '0;
  // Ready is forced low while reset is held so no requester sees a spurious acceptance.
  assign req_ready_o = arst_ni ? ready_vec : '0;

  // Live configuration presented to the core; it is sampled only in the handshake cycle.
  always_comb begin
    cfg_d             = '0;
    cfg_d.div         = CFG_DIV_W'(cfg_clk_div_i);
    cfg_d.parity_en   = cfg_parity_en_i;
    cfg_d.parity_type = cfg_parity_type_i;
    cfg_d.stop2       = cfg_stop2_i;
    cfg_d.data_bits   = cfg_data_bits_i;
  end

  // Pointer and in-flight grant move only on an accepted handshake.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      ptr_q   <= ID_W'(NUM_REQ - 1);
      grant_q <= '0;
    end else if (handshake) begin
      ptr_q   <= sel;
      grant_q <= sel;
    end
  end

  assign grant_id_o = grant_q;
  assign busy_o     = core_busy;

  uart_tx_core #(
    .DIV_W (DIV_W)
  ) u_core (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .start_i (handshake),
    .cfg_i   (cfg_d),
    .data_i  (req_data_i[sel]),
    .tx_o    (tx_o),
    .busy_o  (core_busy)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic            clk = 1'b0;
  logic            arst_n;
  logic [15:0]     cfg_div;
  logic            cfg_par_en;
  logic            cfg_par_odd;
  logic            cfg_stop2;
  logic [3:0]      cfg_dbits;
  logic [3:0][7:0] req_data;
  logic [3:0]      req_valid;
  logic [3:0]      req_ready;
  logic            tx;
  logic            busy;
  logic [1:0]      grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] div;
    logic        par_en;
    logic        par_odd;
    logic        stop2;
    logic [3:0]  dbits;
    int          req;
    logic [7:0]  data;
    int          nbits;
    logic [11:0] bits;
    int          cpb;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ (4),
    .DIV_W   (16)
  ) dut (
    .clk_i             (clk),
    .arst_ni           (arst_n),
    .cfg_clk_div_i     (cfg_div),
    .cfg_parity_en_i   (cfg_par_en),
    .cfg_parity_type_i (cfg_par_odd),
    .cfg_stop2_i       (cfg_stop2),
    .cfg_data_bits_i   (cfg_dbits),
    .req_data_i        (req_data),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .tx_o              (tx),
    .busy_o            (busy),
    .grant_id_o        (grant_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input logic [15:0] d, input logic pe, input logic po,
                         input logic s2, input logic [3:0] db);
    cfg_div     = d;
    cfg_par_en  = pe;
    cfg_par_odd = po;
    cfg_stop2   = s2;
    cfg_dbits   = db;
  endtask

  // Called at posedge+1 of the START cycle; ends at the negedge of the first idle cycle.
  task automatic check_frame(input string name, input logic [11:0] bits, input int nbits,
                             input int cpb, input int gid);
    int errs;
    for (int j = 0; j < nbits; j++) begin
      errs = 0;
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        if (j == 0 && c == 0) check({name, " grant_id"}, grant_id, gid);
        if (tx !== bits[j] || busy !== 1'b1) errs++;
      end
      check($sformatf("%s bit%0d mismatching cycles", name, j), errs, 0);
    end
    @(negedge clk);
    check({name, " busy after frame"}, busy, 0);
    check({name, " tx idle after frame"}, tx, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int errs;
    int cnt;
    int extra;
    int got;
    int order[5];

    vecs[0] = '{16'd4, 1'b0, 1'b0, 1'b0, 4'd8,  0, 8'hA5, 10, 12'h34A, 4};
    vecs[1] = '{16'd2, 1'b1, 1'b1, 1'b1, 4'd8,  1, 8'hA5, 12, 12'hF4A, 2};
    vecs[2] = '{16'd3, 1'b0, 1'b0, 1'b0, 4'd5,  2, 8'hFF,  7, 12'h07E, 3};
    vecs[3] = '{16'd1, 1'b1, 1'b0, 1'b0, 4'd12, 3, 8'h3C, 11, 12'h478, 1};
    vecs[4] = '{16'd0, 1'b1, 1'b0, 1'b1, 4'd5,  0, 8'h0A,  9, 12'h194, 1};
    vecs[5] = '{16'd2, 1'b1, 1'b1, 1'b0, 4'd7,  1, 8'hC1, 10, 12'h382, 2};
    order = '{0, 1, 2, 3, 0};

    // Reset state, with every requester already asking.
    arst_n    = 1'b0;
    req_valid = 4'hF;
    req_data  = '0;
    set_cfg(16'd1, 1'b0, 1'b0, 1'b0, 4'd8);
    repeat (3) @(negedge clk);
    check("reset tx", tx, 1);
    check("reset busy", busy, 0);
    check("reset ready", req_ready, 0);
    check("reset grant_id", grant_id, 0);
    req_valid = 4'h0;
    @(posedge clk); #1;
    arst_n = 1'b1;

    // Idle with nothing pending stays idle.
    errs = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || req_ready !== 4'h0 || tx !== 1'b1) errs++;
    end
    check("idle without valid", errs, 0);

    // All requesters valid continuously: round-robin order and one ready per frame.
    @(posedge clk); #1;
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'hF;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr ready frame%0d", k), req_ready, 4'b0001 << order[k]);
      @(posedge clk); #1;
      if (k == 4) req_valid = 4'h0;
      cnt   = 0;
      extra = 0;
      got   = -1;
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        if (!busy) break;
        if (cnt == 0) got = grant_id;
        cnt++;
        if (req_ready !== 4'h0) extra++;
      end
      check($sformatf("rr grant_id frame%0d", k), got, order[k]);
      check($sformatf("rr frame%0d length", k), cnt, 10);
      check($sformatf("rr frame%0d extra ready", k), extra, 0);
    end

    // Directed frame table; config and data are scrambled right after each handshake.
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      set_cfg(vecs[v].div, vecs[v].par_en, vecs[v].par_odd, vecs[v].stop2, vecs[v].dbits);
      req_data            = '0;
      req_data[vecs[v].req] = vecs[v].data;
      req_valid           = 4'b0001 << vecs[v].req;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (req_ready !== 4'h0) break;
      end
      check($sformatf("vec%0d ready", v), req_ready, 4'b0001 << vecs[v].req);
      @(posedge clk); #1;
      req_valid = 4'h0;
      req_data  = {4{8'h5C}};
      set_cfg(16'd7, ~vecs[v].par_en, ~vecs[v].par_odd, ~vecs[v].stop2, 4'd6);
      check_frame($sformatf("vec%0d", v), vecs[v].bits, vecs[v].nbits, vecs[v].cpb,
                  vecs[v].req);
    end

    // Reset pulse in the middle of DATA, then a fresh frame from requester 1.
    @(posedge clk); #1;
    set_cfg(16'd4, 1'b0, 1'b0, 1'b0, 4'd8);
    req_data    = '0;
    req_valid   = 4'b0100;
    @(negedge clk);
    check("midrst ready req2", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = 4'h0;
    repeat (6) @(posedge clk);
    #2;
    check("midrst tx in DATA", tx, 0);
    check("midrst busy in DATA", busy, 1);
    arst_n      = 1'b0;
    req_data[1] = 8'h5A;
    req_valid   = 4'b0010;
    #1;
    check("midrst tx at reset", tx, 1);
    check("midrst busy at reset", busy, 0);
    check("midrst ready at reset", req_ready, 0);
    check("midrst grant_id at reset", grant_id, 0);
    @(posedge clk);
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(negedge clk);
    check("post-reset ready req1", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = 4'h0;
    check_frame("post-reset", 12'h2B4, 10, 4, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
